// File: rtl/i3c_reg_pkg.sv
// Shared register-bank definitions: register indices, default per-register
// masks and reset values, and the byte-strobe expansion helper.
package i3c_reg_pkg;

  localparam int unsigned MAX_REGS   = 64;
  localparam int unsigned IDX_BCR    = 0;
  localparam int unsigned IDX_DCR    = 1;
  localparam int unsigned IDX_STATUS = 2;
  localparam int unsigned IDX_INT_EN = 3;

  typedef logic [MAX_REGS-1:0][31:0] reg_arr_t;

  function automatic reg_arr_t def_rw_mask();
    reg_arr_t a;
    a             = '0;
    a[IDX_BCR]    = 32'h0000_00FF;
    a[IDX_DCR]    = 32'h0000_00FF;
    a[IDX_INT_EN] = 32'h0000_00FF;
    return a;
  endfunction

  function automatic reg_arr_t def_w1c_mask();
    reg_arr_t a;
    a             = '0;
    a[IDX_STATUS] = 32'h0000_00FF;
    return a;
  endfunction

  localparam reg_arr_t DEF_RW_MASK  = def_rw_mask();
  localparam reg_arr_t DEF_W1C_MASK = def_w1c_mask();
  localparam reg_arr_t DEF_RST_VAL  = '0;

  function automatic logic [31:0] strb_expand(input logic [3:0] strb);
    logic [31:0] m;
    for (int unsigned b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/i3c_reg_bank_bit_cell.sv
// One 32-bit register: merges software RW writes, W1C clears and hardware
// set pulses; bits outside both masks are pinned to their reset value.
module i3c_reg_bit_cell
  import i3c_reg_pkg::*;
#(
  parameter logic [31:0] RW_MASK  = '0,
  parameter logic [31:0] W1C_MASK = '0,
  parameter logic [31:0] RST_VAL  = '0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_we,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_bmask,
  input  logic [31:0] i_hw_set,
  output logic [31:0] o_q
);

  localparam logic [31:0] RO_MASK = ~(RW_MASK | W1C_MASK);

  logic [31:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (i_we) begin
      q_d = (q_d & ~(RW_MASK & i_bmask)) | (i_wdata & RW_MASK & i_bmask);
      q_d = q_d & ~(W1C_MASK & i_bmask & i_wdata);
    end
    // Set is applied after the clear so hardware wins a same-cycle collision.
    q_d = q_d | (i_hw_set & W1C_MASK);
    q_d = (q_d & ~RO_MASK) | (RST_VAL & RO_MASK);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) q_q <= RST_VAL;
    else          q_q <= q_d;
  end

  assign o_q = q_q;

endmodule

// File: rtl/i3c_reg_bank.sv
// Memory-mapped I3C control/status register bank with valid/ready request
// and response channels and a registered interrupt output.
module i3c_reg_bank
  import i3c_reg_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter reg_arr_t    RW_MASK    = DEF_RW_MASK,
  parameter reg_arr_t    W1C_MASK   = DEF_W1C_MASK,
  parameter reg_arr_t    RST_VAL    = DEF_RST_VAL,
  parameter int unsigned STATUS_IDX = IDX_STATUS,
  parameter int unsigned INTEN_IDX  = IDX_INT_EN
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_write,
  input  logic [31:0]              i_addr,
  input  logic [31:0]              i_wdata,
  input  logic [3:0]               i_wstrb,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [31:0]              o_rdata,
  output logic                     o_err,
  input  logic [NUM_REGS*32-1:0]   i_hw_set,
  output logic [NUM_REGS*32-1:0]   o_regs,
  output logic                     o_irq
);

  localparam int unsigned IDXW = $clog2(NUM_REGS);

  logic [31:0]     regs [NUM_REGS];
  logic [31:0]     word_idx;
  logic [IDXW-1:0] idx;
  logic            mapped;
  logic            accept;
  logic [31:0]     bmask;

  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            irq_q, irq_d;

  assign o_ready = ~rsp_valid_q | i_rsp_ready;

  always_comb begin
    word_idx = (i_addr - BASE_ADDR) >> 2;
    mapped   = (i_addr[1:0] == 2'b00) && (word_idx < NUM_REGS);
    idx      = word_idx[IDXW-1:0];
    accept   = i_valid & o_ready;
    bmask    = strb_expand(i_wstrb);
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    i3c_reg_bit_cell #(
      .RW_MASK  (RW_MASK[k]),
      .W1C_MASK (W1C_MASK[k]),
      .RST_VAL  (RST_VAL[k])
    ) u_cell (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_we     (accept && i_write && mapped && (idx == IDXW'(k))),
      .i_wdata  (i_wdata),
      .i_bmask  (bmask),
      .i_hw_set (i_hw_set[32*k +: 32]),
      .o_q      (regs[k])
    );
    assign o_regs[32*k +: 32] = regs[k];
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      err_d       = ~mapped;
      rdata_d     = (mapped && !i_write) ? regs[idx] : '0;
    end else if (i_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    irq_d = |(regs[IDXW'(STATUS_IDX)] & regs[IDXW'(INTEN_IDX)]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rdata     = rdata_q;
  assign o_err       = err_q;
  assign o_irq       = irq_q;

endmodule

// File: tb/tb_i3c_reg_bank.sv
// Self-checking bench for i3c_reg_bank: vector table plus hand sequences,
// responses checked against a queue of expected results.
module tb_i3c_reg_bank;

  localparam int unsigned NR = 8;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_valid;
  logic             o_ready;
  logic             i_write;
  logic [31:0]      i_addr;
  logic [31:0]      i_wdata;
  logic [3:0]       i_wstrb;
  logic             o_rsp_valid;
  logic             i_rsp_ready;
  logic [31:0]      o_rdata;
  logic             o_err;
  logic [NR*32-1:0] i_hw_set;
  logic [NR*32-1:0] o_regs;
  logic             o_irq;

  i3c_reg_bank #(.NUM_REGS(NR), .BASE_ADDR(32'h0000_0000)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_write     (i_write),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_wstrb     (i_wstrb),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rdata     (o_rdata),
    .o_err       (o_err),
    .i_hw_set    (i_hw_set),
    .o_regs      (o_regs),
    .o_irq       (o_irq)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] cur_rdata;
  logic        cur_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] reg_of(input int unsigned k);
    return o_regs[32*k +: 32];
  endfunction

  task automatic add_vec(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] er, input logic ee);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = d; v.strb = s; v.exp_rdata = er; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  // Scoreboard: push at acceptance, compare (and pop on consumption) while a response is shown.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_rsp_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got response %h with no request pending", o_rdata);
        end else begin
          chk("rsp_rdata", o_rdata, sb[0].rdata);
          chk("rsp_err", {31'b0, o_err}, {31'b0, sb[0].err});
          if (i_rsp_ready) void'(sb.pop_front());
        end
      end
      if (i_valid && o_ready) begin
        exp_t e;
        e.rdata = cur_rdata;
        e.err   = cur_err;
        sb.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Starts just after a rising edge; returns just after the accepting edge.
  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] er, input logic ee);
    bit ok;
    i_valid = 1'b1; i_write = w; i_addr = a; i_wdata = d; i_wstrb = s;
    cur_rdata = er; cur_err = ee;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (o_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_accept_timeout: got o_ready=0 expected 1 within 20 cycles (addr %h)", a);
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge i_clk);
    chk("sb_drain_pending", sb.size(), 0);
    step();
  endtask

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_write = 1'b0; i_addr = '0; i_wdata = '0;
    i_wstrb = '0; i_rsp_ready = 1'b1; i_hw_set = '0; cur_rdata = '0; cur_err = 1'b0;

    // Table: back-to-back with i_rsp_ready high, one request per cycle.
    add_vec(0, 32'h00, 32'h0,         4'h0, 32'h0000_0000, 0);
    add_vec(1, 32'h00, 32'hFFFF_FFFF, 4'h1, 32'h0000_0000, 0);
    add_vec(0, 32'h00, 32'h0,         4'h0, 32'h0000_00FF, 0);
    add_vec(1, 32'h00, 32'h0,         4'h2, 32'h0000_0000, 0);
    add_vec(0, 32'h00, 32'h0,         4'hF, 32'h0000_00FF, 0);
    add_vec(1, 32'h04, 32'hA5A5_A5A5, 4'hF, 32'h0000_0000, 0);
    add_vec(0, 32'h04, 32'h0,         4'h0, 32'h0000_00A5, 0);
    add_vec(1, 32'h0C, 32'h1234_5678, 4'h1, 32'h0000_0000, 0);
    add_vec(0, 32'h0C, 32'h0,         4'h0, 32'h0000_0078, 0);
    add_vec(1, 32'h08, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 0);
    add_vec(0, 32'h08, 32'h0,         4'h0, 32'h0000_0000, 0);
    add_vec(1, 32'h10, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 0);
    add_vec(0, 32'h10, 32'h0,         4'h0, 32'h0000_0000, 0);
    add_vec(0, 32'h20, 32'h0,         4'h0, 32'h0000_0000, 1);
    add_vec(1, 32'h20, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1);
    add_vec(0, 32'h02, 32'h0,         4'h0, 32'h0000_0000, 1);
    add_vec(1, 32'h05, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1);
    add_vec(0, 32'h04, 32'h0,         4'h0, 32'h0000_00A5, 0);
    add_vec(0, 32'hFFFF_FFFC, 32'h0,  4'h0, 32'h0000_0000, 1);
    add_vec(1, 32'h00, 32'h0,         4'h0, 32'h0000_0000, 0);
    add_vec(0, 32'h00, 32'h0,         4'h0, 32'h0000_00FF, 0);
    add_vec(1, 32'h1C, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 0);
    add_vec(0, 32'h1C, 32'h0,         4'h0, 32'h0000_0000, 0);

    // Reset values, asynchronously applied.
    #3;
    chk("rst_rsp_valid", {31'b0, o_rsp_valid}, 32'h0);
    chk("rst_rdata", o_rdata, 32'h0);
    chk("rst_err", {31'b0, o_err}, 32'h0);
    chk("rst_irq", {31'b0, o_irq}, 32'h0);
    for (int unsigned k = 0; k < NR; k++) chk($sformatf("rst_reg%0d", k), reg_of(k), 32'h0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("post_rst_ready", {31'b0, o_ready}, 32'h1);
    step();

    foreach (vecs[i]) req(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                          vecs[i].exp_rdata, vecs[i].exp_err);
    drain();
    chk("tbl_bcr", reg_of(0), 32'h0000_00FF);
    chk("tbl_dcr", reg_of(1), 32'h0000_00A5);
    chk("tbl_status", reg_of(2), 32'h0000_0000);
    chk("tbl_inten", reg_of(3), 32'h0000_0078);
    chk("tbl_reg4_ro", reg_of(4), 32'h0000_0000);
    chk("tbl_reg7_ro", reg_of(7), 32'h0000_0000);

    // Hardware set collides with software clear on STATUS bit 0: set wins.
    i_hw_set[2*32] = 1'b1;
    req(1, 32'h08, 32'h1, 4'hF, 32'h0, 0);
    i_hw_set = '0;
    drain();
    chk("collide_status", reg_of(2), 32'h0000_0001);
    req(1, 32'h08, 32'h1, 4'hF, 32'h0, 0);
    drain();
    chk("w1c_clear_status", reg_of(2), 32'h0000_0000);

    // Read returns the pre-set value when a hardware set lands the same cycle.
    i_hw_set[2*32+3] = 1'b1;
    req(0, 32'h08, 32'h0, 4'h0, 32'h0, 0);
    i_hw_set = '0;
    drain();
    chk("read_then_set_status", reg_of(2), 32'h0000_0008);
    req(1, 32'h08, 32'h8, 4'h1, 32'h0, 0);
    drain();
    chk("clear_bit3_status", reg_of(2), 32'h0000_0000);

    // Interrupt timing.
    req(1, 32'h0C, 32'h1, 4'hF, 32'h0, 0);
    drain();
    chk("irq_idle", {31'b0, o_irq}, 32'h0);
    i_hw_set[2*32] = 1'b1;
    @(posedge i_clk);
    #1 i_hw_set = '0;
    @(negedge i_clk);
    chk("irq_set_status", reg_of(2), 32'h1);
    chk("irq_lag1", {31'b0, o_irq}, 32'h0);
    @(negedge i_clk);
    chk("irq_asserted", {31'b0, o_irq}, 32'h1);
    step();
    req(1, 32'h08, 32'h1, 4'h1, 32'h0, 0);
    @(negedge i_clk);
    chk("irq_clr_status", reg_of(2), 32'h0);
    chk("irq_clr_lag", {31'b0, o_irq}, 32'h1);
    @(negedge i_clk);
    chk("irq_deasserted", {31'b0, o_irq}, 32'h0);
    drain();

    // Backpressure: response held three cycles, then released.
    i_rsp_ready = 1'b0;
    req(0, 32'h00, 32'h0, 4'h0, 32'h0000_00FF, 0);
    fork
      req(0, 32'h04, 32'h0, 4'h0, 32'h0000_00A5, 0);
      begin
        repeat (3) begin
          @(negedge i_clk);
          chk("bp_ready_low", {31'b0, o_ready}, 32'h0);
          chk("bp_rsp_held", {31'b0, o_rsp_valid}, 32'h1);
        end
        @(posedge i_clk);
        #1 i_rsp_ready = 1'b1;
        #1 chk("bp_ready_release", {31'b0, o_ready}, 32'h1);
      end
    join
    drain();

    // Pending response dropped by reset; registers return to reset value.
    req(1, 32'h00, 32'h5A, 4'hF, 32'h0, 0);
    drain();
    chk("pre_rst_bcr", reg_of(0), 32'h0000_005A);
    i_rsp_ready = 1'b0;
    req(0, 32'h00, 32'h0, 4'h0, 32'h0000_005A, 0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_drop_valid", {31'b0, o_rsp_valid}, 32'h0);
    chk("rst_drop_rdata", o_rdata, 32'h0);
    chk("rst_drop_bcr", reg_of(0), 32'h0);
    sb.delete();
    step();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst_drop_ready", {31'b0, o_ready}, 32'h1);
    chk("rst_drop_no_rsp", {31'b0, o_rsp_valid}, 32'h0);
    i_rsp_ready = 1'b1;
    step();
    req(0, 32'h00, 32'h0, 4'h0, 32'h0, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running expected finish");
    $fatal(1, "timeout");
  end

endmodule
